// File: rtl/dtree_ens_walker_if.sv
// dtree_ens_walker bus: node-table config port, feature-vector input
// handshake and result output handshake (master = producer side).
interface dtree_ens_walker_if #(
  parameter int N_FEAT = 51,
  parameter int AW = 6,
  parameter int NW = 20,
  parameter int VW = 2
);
  logic cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [NW-1:0] cfg_data;
  logic cfg_busy;
  logic in_valid;
  logic in_ready;
  logic [N_FEAT-1:0] i;
  logic out_valid;
  logic out_ready;
  logic o;
  logic [VW-1:0] out_votes;
  logic out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data,
    output in_valid, i, out_ready,
    input cfg_busy, in_ready,
    input out_valid, o, out_votes, out_err
  );

  modport slave (
    input cfg_we, cfg_addr, cfg_data,
    input in_valid, i, out_ready,
    output cfg_busy, in_ready,
    output out_valid, o, out_votes, out_err
  );
endinterface

// File: rtl/dtree_ens_walker.sv
// Table-driven tree-ensemble walker: clk, rst_n, bus (cfg/in/out handshakes).
// Optional TREE_STEP_LIMIT_EN adds a per-tree step limit and out_err.
module dtree_ens_walker #(
  parameter int N_FEAT = 51,
  parameter int N_NODES = 64,
  parameter int N_TREES = 3,
  parameter int MAX_STEPS = 16
) (
  input logic clk,
  input logic rst_n,
  dtree_ens_walker_if.slave bus
);
  localparam int FW = $clog2(N_FEAT);
  localparam int AW = $clog2(N_NODES);
  localparam int NW = 2 + FW + 2 * AW;
  localparam int VW = $clog2(N_TREES + 1);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t state_q, state_d;
  logic [NW-1:0] mem [N_NODES];
  logic [N_FEAT-1:0] feat_q, feat_d;
  logic [AW-1:0] tree_q, tree_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [VW-1:0] votes_q, votes_d;
  logic ov_q, ov_d;
  logic next_tree;

  logic [NW-1:0] node;
  logic is_leaf, cls, fbit, last;
  logic [FW-1:0] fidx;
  logic [AW-1:0] tptr, fptr;
  logic [2**FW-1:0] feat_ext;
  logic [VW:0] dbl;

  assign node = mem[ptr_q];
  assign is_leaf = node[NW-1];
  assign cls = node[NW-2];
  assign fidx = node[2*AW+FW-1:2*AW];
  assign tptr = node[2*AW-1:AW];
  assign fptr = node[AW-1:0];
  assign feat_ext = (2**FW)'(feat_q);
  // Indices past the vector read as 0.
  assign fbit = feat_ext[fidx]
    & ({1'b0, fidx} < (FW+1)'(N_FEAT));
  assign last = tree_q == AW'(N_TREES - 1);

`ifdef TREE_STEP_LIMIT_EN
  localparam int SW = $clog2(MAX_STEPS + 1);
  logic [SW-1:0] steps_q, steps_d;
  logic err_q, err_d;
`else
  logic unused_max_steps;
  assign unused_max_steps = (MAX_STEPS > 0);
`endif

  always_ff @(posedge clk) begin
    if (bus.cfg_we && state_q == IDLE)
      mem[bus.cfg_addr] <= bus.cfg_data;
  end

  always_comb begin
    state_d = state_q;
    feat_d = feat_q;
    tree_d = tree_q;
    ptr_d = ptr_q;
    votes_d = votes_q;
    ov_d = ov_q;
    next_tree = 1'b0;
`ifdef TREE_STEP_LIMIT_EN
    steps_d = steps_q;
    err_d = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          feat_d = bus.i;
          tree_d = '0;
          ptr_d = '0;
          votes_d = '0;
`ifdef TREE_STEP_LIMIT_EN
          steps_d = '0;
          err_d = 1'b0;
`endif
          state_d = WALK;
        end
      end
      WALK: begin
        if (is_leaf) begin
          if (cls && votes_q != VW'(N_TREES))
            votes_d = votes_q + VW'(1);
          next_tree = 1'b1;
        end else begin
          ptr_d = fbit ? tptr : fptr;
`ifdef TREE_STEP_LIMIT_EN
          // This visit is the limit-th non-leaf: abandon the tree.
          if (steps_q == SW'(MAX_STEPS - 1)) begin
            err_d = 1'b1;
            next_tree = 1'b1;
          end else begin
            steps_d = steps_q + SW'(1);
          end
`endif
        end
        if (next_tree) begin
          if (last) begin
            state_d = DONE;
          end else begin
            tree_d = tree_q + AW'(1);
            ptr_d = tree_q + AW'(1);
`ifdef TREE_STEP_LIMIT_EN
            steps_d = '0;
`endif
          end
        end
      end
      DONE: begin
        // One settle cycle before the result is presented.
        if (!ov_q) begin
          ov_d = 1'b1;
        end else if (bus.out_ready) begin
          ov_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      feat_q <= '0;
      tree_q <= '0;
      ptr_q <= '0;
      votes_q <= '0;
      ov_q <= 1'b0;
`ifdef TREE_STEP_LIMIT_EN
      steps_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      feat_q <= feat_d;
      tree_q <= tree_d;
      ptr_q <= ptr_d;
      votes_q <= votes_d;
      ov_q <= ov_d;
`ifdef TREE_STEP_LIMIT_EN
      steps_q <= steps_d;
      err_q <= err_d;
`endif
    end
  end

  assign dbl = {votes_q, 1'b0};
  assign bus.o = dbl > (VW+1)'(N_TREES);
  assign bus.out_votes = votes_q;
  assign bus.out_valid = ov_q;
  assign bus.in_ready = state_q == IDLE;
  assign bus.cfg_busy = state_q != IDLE;
`ifdef TREE_STEP_LIMIT_EN
  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif
endmodule
